// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU dispatcher slice.
// Op codes, unit indices, special results and the decoded operand bundle.
package fpu_pkg;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      MUL = 2'd2,
      DIV = 2'd3
   } op_t;

   localparam int UNIT_ADD = 0;
   localparam int UNIT_MUL = 1;
   localparam int UNIT_DIV = 2;

   localparam logic [31:0] QNAN = 32'h7FFFFFFF;
   localparam logic [31:0] INF  = 32'h7F800000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   typedef struct packed {
      logic        x_sign;
      logic        y_sign;
      logic [7:0]  x_exp;
      logic [7:0]  y_exp;
      logic [22:0] x_frac;
      logic [22:0] y_frac;
      logic        x_greater;
      logic [7:0]  exp_shift;
      logic        x_inf;
      logic        y_inf;
      logic        x_nan;
      logic        y_nan;
   } dec_t;

   // SUB runs on the adder with y negated.
   function automatic logic [1:0] unit_of(op_t op);
      logic [1:0] u;
      u = 2'(UNIT_ADD);
      unique case (op)
         ADD, SUB: u = 2'(UNIT_ADD);
         MUL:      u = 2'(UNIT_MUL);
         DIV:      u = 2'(UNIT_DIV);
      endcase
      return u;
   endfunction

endpackage

// File: rtl/fp_operand_decode.sv
// Combinational split of two packed singles into unit operand fields.
// Also derives class flags, magnitude order and exponent distance.
module fp_operand_decode
   import fpu_pkg::*;
(
   input  logic [31:0] x,
   input  logic [31:0] y,
   output dec_t        dec
);

   // Field extraction and magnitude compare.
   always_comb begin
      dec           = '0;
      dec.x_sign    = x[31];
      dec.y_sign    = y[31];
      dec.x_exp     = x[30:23];
      dec.y_exp     = y[30:23];
      dec.x_frac    = x[22:0];
      dec.y_frac    = y[22:0];
      dec.x_inf     = (x[30:23] == 8'hFF) && (x[22:0] == '0);
      dec.y_inf     = (y[30:23] == 8'hFF) && (y[22:0] == '0);
      dec.x_nan     = (x[30:23] == 8'hFF) && (x[22:0] != '0);
      dec.y_nan     = (y[30:23] == 8'hFF) && (y[22:0] != '0);
      dec.x_greater = (x[30:23] > y[30:23]) ||
                      ((x[30:23] == y[30:23]) && (x[22:0] >= y[22:0]));
      dec.exp_shift = dec.x_greater ? (x[30:23] - y[30:23])
                                    : (y[30:23] - x[30:23]);
   end

endmodule

// File: rtl/fpu_dispatcher.sv
// Single-request front end for the FPU adder, multiplier and divider.
// Decodes operands, issues to one unit, waits for done or watchdog expiry.
module fpu_dispatcher
   import fpu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [1:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        resp_valid_o,
   output logic [31:0] z_o,
   output logic        except_invalid_operation_o,
   output logic        except_overflow_o,
   output logic        timeout_o,
   output logic [2:0]  unit_valid_o,
   output logic        x_sign_o,
   output logic        y_sign_o,
   output logic [7:0]  x_exp_o,
   output logic [7:0]  y_exp_o,
   output logic [22:0] x_frac_o,
   output logic [22:0] y_frac_o,
   output logic        x_greater_o,
   output logic [7:0]  exp_shift_o,
   output logic        x_infinity_o,
   output logic        y_infinity_o,
   output logic        x_nan_o,
   output logic        y_nan_o,
   input  logic [2:0]  unit_done_i,
   input  logic [95:0] unit_z_i,
   input  logic [2:0]  unit_invalid_i,
   input  logic [2:0]  unit_overflow_i
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t     state, nxt;
   logic [1:0] sel;
   logic [CNT_W-1:0] cnt;
   dec_t       dec, dec_q;
   logic [31:0] b_eff;
   logic       accept, done, expire;

   assign b_eff  = (op_t'(op_i) == SUB) ? {~b_i[31], b_i[30:0]} : b_i;
   assign accept = (state == S_IDLE) && req_valid_i;
   assign done   = unit_done_i[sel];
   assign expire = (cnt == CNT_MAX);

   fp_operand_decode u_dec (
      .x   (a_i),
      .y   (b_eff),
      .dec (dec)
   );

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= nxt;
   end

   // Next-state logic; done beats watchdog expiry.
   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:  if (req_valid_i) nxt = S_ISSUE;
         S_ISSUE: nxt = S_WAIT;
         S_WAIT:  if (done || expire) nxt = S_RESP;
         S_RESP:  nxt = S_IDLE;
      endcase
   end

   // Operand capture, issue strobe, watchdog and result capture.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sel          <= '0;
         dec_q        <= '0;
         cnt          <= '0;
         unit_valid_o <= '0;
         resp_valid_o <= 1'b0;
         z_o          <= '0;
         timeout_o    <= 1'b0;
         except_invalid_operation_o <= 1'b0;
         except_overflow_o          <= 1'b0;
      end else begin
         unit_valid_o <= '0;
         resp_valid_o <= 1'b0;
         if (accept) begin
            sel          <= unit_of(op_t'(op_i));
            dec_q        <= dec;
            unit_valid_o <= 3'(1) << unit_of(op_t'(op_i));
         end
         if (state == S_ISSUE) cnt <= '0;
         if (state == S_WAIT) begin
            if (done) begin
               z_o          <= unit_z_i[{sel, 5'd0} +: 32];
               timeout_o    <= 1'b0;
               resp_valid_o <= 1'b1;
               except_invalid_operation_o <= unit_invalid_i[sel];
               except_overflow_o          <= unit_overflow_i[sel];
            end else if (expire) begin
               z_o          <= QNAN;
               timeout_o    <= 1'b1;
               resp_valid_o <= 1'b1;
               except_invalid_operation_o <= 1'b0;
               except_overflow_o          <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign req_ready_o  = (state == S_IDLE);
   assign x_sign_o     = dec_q.x_sign;
   assign y_sign_o     = dec_q.y_sign;
   assign x_exp_o      = dec_q.x_exp;
   assign y_exp_o      = dec_q.y_exp;
   assign x_frac_o     = dec_q.x_frac;
   assign y_frac_o     = dec_q.y_frac;
   assign x_greater_o  = dec_q.x_greater;
   assign exp_shift_o  = dec_q.exp_shift;
   assign x_infinity_o = dec_q.x_inf;
   assign y_infinity_o = dec_q.y_inf;
   assign x_nan_o      = dec_q.x_nan;
   assign y_nan_o      = dec_q.y_nan;

endmodule

// File: tb/tb_fpu_dispatcher.sv
// Directed bench for fpu_dispatcher with an 8-cycle watchdog.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fpu_dispatcher;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [1:0]  op_i;
   logic [31:0] a_i, b_i;
   logic        resp_valid_o;
   logic [31:0] z_o;
   logic        inv_o, ovf_o, timeout_o;
   logic [2:0]  unit_valid_o;
   logic        x_sign_o, y_sign_o;
   logic [7:0]  x_exp_o, y_exp_o;
   logic [22:0] x_frac_o, y_frac_o;
   logic        x_greater_o;
   logic [7:0]  exp_shift_o;
   logic        x_inf_o, y_inf_o, x_nan_o, y_nan_o;
   logic [2:0]  unit_done_i;
   logic [95:0] unit_z_i;
   logic [2:0]  unit_invalid_i, unit_overflow_i;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk_i = ~clk_i;

   fpu_dispatcher #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
      .clk_i                      (clk_i),
      .rst_i                      (rst_i),
      .req_valid_i                (req_valid_i),
      .req_ready_o                (req_ready_o),
      .op_i                       (op_i),
      .a_i                        (a_i),
      .b_i                        (b_i),
      .resp_valid_o               (resp_valid_o),
      .z_o                        (z_o),
      .except_invalid_operation_o (inv_o),
      .except_overflow_o          (ovf_o),
      .timeout_o                  (timeout_o),
      .unit_valid_o               (unit_valid_o),
      .x_sign_o                   (x_sign_o),
      .y_sign_o                   (y_sign_o),
      .x_exp_o                    (x_exp_o),
      .y_exp_o                    (y_exp_o),
      .x_frac_o                   (x_frac_o),
      .y_frac_o                   (y_frac_o),
      .x_greater_o                (x_greater_o),
      .exp_shift_o                (exp_shift_o),
      .x_infinity_o               (x_inf_o),
      .y_infinity_o               (y_inf_o),
      .x_nan_o                    (x_nan_o),
      .y_nan_o                    (y_nan_o),
      .unit_done_i                (unit_done_i),
      .unit_z_i                   (unit_z_i),
      .unit_invalid_i             (unit_invalid_i),
      .unit_overflow_i            (unit_overflow_i)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: got %h want %h", tag, obs, exp_v);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      req_valid_i = 1'b0;
      op_i = 2'd0;
      a_i = '0;
      b_i = '0;
      unit_done_i = '0;
      unit_z_i = '0;
      unit_invalid_i = '0;
      unit_overflow_i = '0;
      tick();
      tick();
      rst_i = 1'b0;
      tick();
      chk("rst_ready", 32'(req_ready_o), 32'd1);
      chk("rst_resp", 32'(resp_valid_o), 32'd0);
      chk("rst_z", z_o, 32'd0);
      chk("rst_uv", 32'(unit_valid_o), 32'd0);

      // ADD 1.0 + 2.0
      req_valid_i = 1'b1; op_i = 2'd0;
      a_i = 32'h3F800000; b_i = 32'h40000000;
      tick();
      req_valid_i = 1'b0;
      chk("add_uv", 32'(unit_valid_o), 32'd1);
      chk("add_xexp", 32'(x_exp_o), 32'd127);
      chk("add_yexp", 32'(y_exp_o), 32'd128);
      chk("add_xg", 32'(x_greater_o), 32'd0);
      chk("add_shift", 32'(exp_shift_o), 32'd1);
      chk("add_ready", 32'(req_ready_o), 32'd0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("add_uv_off", 32'(unit_valid_o), 32'd0);
      end
      unit_done_i = 3'b001; unit_z_i[31:0] = 32'h40400000;
      tick();
      unit_done_i = '0;
      chk("add_resp", 32'(resp_valid_o), 32'd1);
      chk("add_z", z_o, 32'h40400000);
      chk("add_flags", {29'd0, inv_o, ovf_o, timeout_o}, 32'd0);
      tick();
      chk("add_resp_end", 32'(resp_valid_o), 32'd0);
      chk("add_z_hold", z_o, 32'h40400000);
      chk("add_ready_back", 32'(req_ready_o), 32'd1);

      // SUB 3.0 - 1.0
      req_valid_i = 1'b1; op_i = 2'd1;
      a_i = 32'h40400000; b_i = 32'h3F800000;
      tick();
      req_valid_i = 1'b0;
      chk("sub_uv", 32'(unit_valid_o), 32'd1);
      chk("sub_ysign", 32'(y_sign_o), 32'd1);
      chk("sub_xsign", 32'(x_sign_o), 32'd0);
      chk("sub_xg", 32'(x_greater_o), 32'd1);
      chk("sub_shift", 32'(exp_shift_o), 32'd1);
      tick();
      unit_done_i = 3'b001; unit_z_i[31:0] = 32'h40000000;
      tick();
      unit_done_i = '0;
      chk("sub_z", z_o, 32'h40000000);
      tick();

      // DIV NaN / 1.0 with a stray adder done
      req_valid_i = 1'b1; op_i = 2'd3;
      a_i = 32'h7FC00000; b_i = 32'h3F800000;
      tick();
      req_valid_i = 1'b0;
      chk("div_uv", 32'(unit_valid_o), 32'd4);
      chk("div_xnan", 32'(x_nan_o), 32'd1);
      chk("div_xinf", 32'(x_inf_o), 32'd0);
      chk("div_ynan", 32'(y_nan_o), 32'd0);
      tick();
      unit_done_i = 3'b001; unit_z_i[31:0] = 32'h12345678;
      tick();
      unit_done_i = '0;
      chk("div_stray", 32'(resp_valid_o), 32'd0);
      unit_done_i = 3'b100; unit_invalid_i = 3'b100;
      unit_z_i[95:64] = 32'h7FFFFFFF;
      tick();
      unit_done_i = '0; unit_invalid_i = '0;
      chk("div_resp", 32'(resp_valid_o), 32'd1);
      chk("div_z", z_o, 32'h7FFFFFFF);
      chk("div_inv", 32'(inv_o), 32'd1);
      chk("div_ovf", 32'(ovf_o), 32'd0);
      tick();

      // MUL timeout; a done during ISSUE must be ignored
      req_valid_i = 1'b1; op_i = 2'd2;
      a_i = 32'h40000000; b_i = 32'h40000000;
      tick();
      req_valid_i = 1'b0;
      chk("to_uv", 32'(unit_valid_o), 32'd2);
      unit_done_i = 3'b010; unit_z_i[63:32] = 32'h40800000;
      for (int i = 1; i <= 8; i++) begin
         tick();
         unit_done_i = '0;
         chk("to_wait", 32'(resp_valid_o), 32'd0);
      end
      tick();
      chk("to_resp", 32'(resp_valid_o), 32'd1);
      chk("to_z", z_o, 32'h7FFFFFFF);
      chk("to_flag", 32'(timeout_o), 32'd1);
      chk("to_inv_clr", 32'(inv_o), 32'd0);
      tick();

      // MUL done in the expiry cycle
      req_valid_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      chk("col_uv", 32'(unit_valid_o), 32'd2);
      for (int i = 1; i <= 8; i++) tick();
      unit_done_i = 3'b010; unit_overflow_i = 3'b010;
      unit_z_i[63:32] = 32'h41000000;
      tick();
      unit_done_i = '0; unit_overflow_i = '0;
      chk("col_resp", 32'(resp_valid_o), 32'd1);
      chk("col_to", 32'(timeout_o), 32'd0);
      chk("col_z", z_o, 32'h41000000);
      chk("col_ovf", 32'(ovf_o), 32'd1);
      tick();

      // Back-pressure with req_valid_i held high
      req_valid_i = 1'b1; op_i = 2'd0;
      a_i = 32'h3F800000; b_i = 32'h40000000;
      tick();
      chk("bp_issue_rdy", 32'(req_ready_o), 32'd0);
      tick();
      chk("bp_wait_rdy", 32'(req_ready_o), 32'd0);
      chk("bp_wait_uv", 32'(unit_valid_o), 32'd0);
      unit_done_i = 3'b001; unit_z_i[31:0] = 32'h40400000;
      tick();
      unit_done_i = '0;
      chk("bp_resp_rdy", 32'(req_ready_o), 32'd0);
      chk("bp_resp", 32'(resp_valid_o), 32'd1);
      tick();
      chk("bp_idle_rdy", 32'(req_ready_o), 32'd1);
      chk("bp_idle_uv", 32'(unit_valid_o), 32'd0);
      tick();
      chk("bp_second", 32'(unit_valid_o), 32'd1);
      tick();
      tick();

      // Reset mid-WAIT
      rst_i = 1'b1;
      req_valid_i = 1'b0;
      #1;
      chk("rst_z0", z_o, 32'd0);
      chk("rst_xexp0", 32'(x_exp_o), 32'd0);
      chk("rst_yexp0", 32'(y_exp_o), 32'd0);
      chk("rst_resp0", 32'(resp_valid_o), 32'd0);
      chk("rst_uv0", 32'(unit_valid_o), 32'd0);
      tick();
      rst_i = 1'b0;
      unit_done_i = 3'b001;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_resp", 32'(resp_valid_o), 32'd0);
         chk("post_rst_rdy", 32'(req_ready_o), 32'd1);
      end
      unit_done_i = '0;

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
